// File: rtl/axis_load_sequencer.sv
// Control-period scheduler: latches host setpoints into shadow registers and, on each
// period tick, loads a committed set into the four axis generators with a common WR strobe.
module axis_load_sequencer #(
    parameter int unsigned TICK_CYCLES = 20000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned STROBE_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_wr,
    input  logic [2:0]  host_addr,
    input  logic [7:0]  host_data,
    input  logic        host_commit,
    input  logic        host_clr,
    input  logic [3:0]  busy_in,
    output logic [31:0] N_out,
    output logic [3:0]  WR_out,
    output logic        tick_out,
    output logic [3:0]  overrun,
    output logic        underrun,
    output logic        seq_busy
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned PW = $clog2(SETUP_CYC + STROBE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE} state_t;

    logic [2:0]       wr_sync_q, wr_sync_d;
    logic [2:0]       cm_sync_q, cm_sync_d;
    logic [2:0]       clr_sync_q, clr_sync_d;
    logic [3:0][7:0]  shadow_q, shadow_d;
    logic [3:0][7:0]  n_q, n_d;
    logic [3:0]       en_mask_q, en_mask_d;
    logic [3:0]       mask_run_q, mask_run_d;
    logic             pending_q, pending_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ph_q, ph_d;
    state_t           state_q, state_d;
    logic [3:0]       wr_q, wr_d;
    logic             tick_q, tick_d;
    logic [3:0]       ovr_q, ovr_d;
    logic             und_q, und_d;
    logic             busy_q, busy_d;

    logic             wr_ev, cm_ev, clr_ev, tick_edge;
    logic [3:0]       ovr_set;
    logic             und_set;

    // Rising-edge detect on the third flop of each host synchroniser
    assign wr_ev     = wr_sync_q[1]  & ~wr_sync_q[2];
    assign cm_ev     = cm_sync_q[1]  & ~cm_sync_q[2];
    assign clr_ev    = clr_sync_q[1] & ~clr_sync_q[2];
    assign tick_edge = (cnt_q == CW'(TICK_CYCLES - 1));

    always_comb begin
        wr_sync_d  = {wr_sync_q[1:0], host_wr};
        cm_sync_d  = {cm_sync_q[1:0], host_commit};
        clr_sync_d = {clr_sync_q[1:0], host_clr};
        shadow_d   = shadow_q;
        n_d        = n_q;
        en_mask_d  = en_mask_q;
        mask_run_d = mask_run_q;
        pending_d  = pending_q;
        cnt_d      = tick_edge ? '0 : cnt_q + CW'(1);
        ph_d       = ph_q;
        state_d    = state_q;
        wr_d       = wr_q;
        tick_d     = tick_edge;
        busy_d     = busy_q;
        ovr_set    = 4'b0000;
        und_set    = 1'b0;

        // Host writes land after the tick has copied the old shadow
        if (wr_ev) begin
            if (!host_addr[2]) begin
                shadow_d[host_addr[1:0]] = host_data;
            end else if (host_addr == 3'd4) begin
                en_mask_d = host_data[3:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tick_edge) begin
                    if (pending_q) begin
                        n_d        = shadow_q;
                        mask_run_d = en_mask_q;
                        ovr_set    = en_mask_q & busy_in;
                        pending_d  = 1'b0;
                        ph_d       = '0;
                        busy_d     = 1'b1;
                        state_d    = S_SETUP;
                    end else begin
                        und_set = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (ph_q == PW'(SETUP_CYC - 1)) begin
                    ph_d    = '0;
                    wr_d    = mask_run_q;
                    state_d = S_STROBE;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_STROBE: begin
                if (ph_q == PW'(STROBE_CYC - 1)) begin
                    ph_d    = '0;
                    wr_d    = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: begin
                wr_d    = 4'b0000;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A commit coinciding with the tick re-arms pending for the following period
        if (cm_ev) begin
            pending_d = 1'b1;
        end

        ovr_d = (clr_ev ? 4'b0000 : ovr_q) | ovr_set;
        und_d = (clr_ev ? 1'b0    : und_q) | und_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sync_q  <= '0;
            cm_sync_q  <= '0;
            clr_sync_q <= '0;
            shadow_q   <= '0;
            n_q        <= '0;
            en_mask_q  <= 4'hF;
            mask_run_q <= 4'hF;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            ph_q       <= '0;
            state_q    <= S_IDLE;
            wr_q       <= 4'b0000;
            tick_q     <= 1'b0;
            ovr_q      <= 4'b0000;
            und_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_sync_q  <= wr_sync_d;
            cm_sync_q  <= cm_sync_d;
            clr_sync_q <= clr_sync_d;
            shadow_q   <= shadow_d;
            n_q        <= n_d;
            en_mask_q  <= en_mask_d;
            mask_run_q <= mask_run_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            state_q    <= state_d;
            wr_q       <= wr_d;
            tick_q     <= tick_d;
            ovr_q      <= ovr_d;
            und_q      <= und_d;
            busy_q     <= busy_d;
        end
    end

    assign N_out    = n_q;
    assign WR_out   = wr_q;
    assign tick_out = tick_q;
    assign overrun  = ovr_q;
    assign underrun = und_q;
    assign seq_busy = busy_q;

endmodule

// File: tb/tb_axis_load_sequencer.sv
// Scoreboard bench for axis_load_sequencer: stimulus queues the expected result of each
// period tick, a monitor checks outputs and the WR strobe window around every tick.
module tb_axis_load_sequencer;

    localparam int unsigned T  = 64;
    localparam int unsigned SU = 2;
    localparam int unsigned ST = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_wr, host_commit, host_clr;
    logic [2:0]  host_addr;
    logic [7:0]  host_data;
    logic [3:0]  busy_in;
    logic [31:0] N_out;
    logic [3:0]  WR_out;
    logic        tick_out;
    logic [3:0]  overrun;
    logic        underrun;
    logic        seq_busy;

    typedef struct packed {
        logic [31:0] n;
        logic        load;
        logic [3:0]  wr;
        logic [3:0]  ovr;
        logic        und;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tb_cnt;

    axis_load_sequencer #(.TICK_CYCLES(T), .SETUP_CYC(SU), .STROBE_CYC(ST)) dut (
        .clk(clk), .rst(rst), .host_wr(host_wr), .host_addr(host_addr),
        .host_data(host_data), .host_commit(host_commit), .host_clr(host_clr),
        .busy_in(busy_in), .N_out(N_out), .WR_out(WR_out), .tick_out(tick_out),
        .overrun(overrun), .underrun(underrun), .seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

    // Bench-side period position, used only to time host events onto the tick edge
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == int'(T - 1)) ? 0 : tb_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        host_addr = a;
        host_data = d;
        host_wr   = 1'b1;
        repeat (6) @(negedge clk);
        host_wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_pulse(input bit is_clr);
        if (is_clr) host_clr = 1'b1;
        else        host_commit = 1'b1;
        repeat (6) @(negedge clk);
        host_clr    = 1'b0;
        host_commit = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tick();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!tick_out && i < int'(2 * T));
        chk("tick_wait", {31'd0, tick_out}, 32'd1);
    endtask

    task automatic wait_cnt(input int k);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (tb_cnt != k && i < int'(2 * T));
    endtask

    task automatic push(input logic [31:0] n, input logic load, input logic [3:0] wr,
                        input logic [3:0] ovr, input logic und);
        exp_t e;
        e.n = n; e.load = load; e.wr = wr; e.ovr = ovr; e.und = und;
        exp_q.push_back(e);
    endtask

    // Monitor: on each tick_out cycle (E+1) compare against the next queued expectation
    always begin
        exp_t e;
        @(negedge clk);
        if (tick_out && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("n_out",    N_out, e.n);
            chk("overrun",  {28'd0, overrun}, {28'd0, e.ovr});
            chk("underrun", {31'd0, underrun}, {31'd0, e.und});
            chk("busy_e1",  {31'd0, seq_busy}, {31'd0, e.load});
            @(negedge clk);
            chk("wr_setup", {28'd0, WR_out}, 32'd0);
            @(negedge clk);
            chk("wr_e3",    {28'd0, WR_out}, {28'd0, e.wr});
            @(negedge clk);
            chk("wr_e4",    {28'd0, WR_out}, {28'd0, e.wr});
            @(negedge clk);
            chk("wr_e5",    {28'd0, WR_out}, 32'd0);
            chk("busy_e5",  {31'd0, seq_busy}, 32'd0);
        end
    end

    initial begin
        int wr_seen;
        int i;
        rst = 1'b1; host_wr = 1'b0; host_commit = 1'b0; host_clr = 1'b0;
        host_addr = 3'd0; host_data = 8'd0; busy_in = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_n_out",    N_out, 32'd0);
        chk("rst_wr",       {28'd0, WR_out}, 32'd0);
        chk("rst_tick",     {31'd0, tick_out}, 32'd0);
        chk("rst_overrun",  {28'd0, overrun}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_busy",     {31'd0, seq_busy}, 32'd0);
        rst = 1'b0;

        // First load: both axes, all enabled
        host_write(3'd0, 8'h85);
        host_write(3'd1, 8'h32);
        host_pulse(1'b0);
        push(32'h0000_3285, 1'b1, 4'hF, 4'h0, 1'b0);
        wait_tick();

        // Period with no commit
        push(32'h0000_3285, 1'b0, 4'h0, 4'h0, 1'b1);
        wait_tick();

        // Clear underrun, mask 0101, axes 0/1 busy at the tick
        busy_in = 4'b0011;
        host_pulse(1'b1);
        chk("clr_underrun", {31'd0, underrun}, 32'd0);
        host_write(3'd4, 8'h05);
        host_pulse(1'b0);
        push(32'h0000_3285, 1'b1, 4'b0101, 4'b0001, 1'b0);
        wait_tick();
        busy_in = 4'b0000;

        // Commit event lands exactly on the tick edge
        push(32'h0000_3285, 1'b0, 4'h0, 4'b0001, 1'b1);
        wait_cnt(int'(T) - 3);
        host_pulse(1'b0);
        push(32'h0000_3285, 1'b1, 4'b0101, 4'b0001, 1'b1);
        wait_tick();

        // Write event on the tick edge: old shadow loaded, new value next period
        wait_cnt(2);
        host_write(3'd2, 8'h10);
        host_pulse(1'b0);
        push(32'h0010_3285, 1'b1, 4'b0101, 4'b0001, 1'b1);
        wait_cnt(int'(T) - 3);
        host_write(3'd2, 8'h20);
        host_pulse(1'b0);
        push(32'h0020_3285, 1'b1, 4'b0101, 4'b0001, 1'b1);
        wait_tick();

        // Clear sticky flags, then reset in the middle of a strobe
        host_pulse(1'b1);
        chk("clr_overrun",  {28'd0, overrun}, 32'd0);
        chk("clr_underrun2", {31'd0, underrun}, 32'd0);
        host_pulse(1'b0);
        wait_tick();
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (WR_out == 4'b0000 && i < 8);
        chk("wr_before_rst", {28'd0, WR_out}, 32'h5);
        rst = 1'b1;
        #1;
        chk("rst_async_wr",   {28'd0, WR_out}, 32'd0);
        chk("rst_async_n",    N_out, 32'd0);
        chk("rst_async_busy", {31'd0, seq_busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(32'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        wr_seen = 0;
        i = 0;
        do begin
            @(negedge clk);
            if (WR_out != 4'b0000) wr_seen++;
            i++;
        end while (!tick_out && i < int'(T + 5));
        chk("post_rst_tick", {31'd0, tick_out}, 32'd1);
        chk("post_rst_wr",   wr_seen, 32'd0);
        chk("post_rst_cycles", i, T);

        i = 0;
        while (exp_q.size() > 0 && i < int'(3 * T)) begin
            @(negedge clk);
            i++;
        end
        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_load_sequencer.md
# axis_load_sequencer

Control-period scheduler for the four per-axis step-pulse generators. It takes setpoint bytes from the host MCU parallel bus into shadow registers. On each 1 ms control tick it transfers a committed set to the generators' N inputs together and strobes their WR lines in one cycle. It also reports per-axis overrun (generator still busy at load) and period underrun (no new set committed) to the host.

## Interface
- TICK_CYCLES, 20000: clk cycles per control period (1 ms at 20 MHz).
- SETUP_CYC, 2: cycles N_out is held stable before WR_out rises.
- STROBE_CYC, 2: cycles WR_out stays high.
- Constraint: SETUP_CYC ≥ 1, STROBE_CYC ≥ 1, SETUP_CYC + STROBE_CYC < TICK_CYCLES.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- host_wr  in  1  host write strobe, asynchronous to clk; acts on its rising edge.
- host_addr  in  3  register address: 0–3 are axis N, 4 is enable mask (bits 3:0), 5–7 are ignored.
- host_data  in  8  write data. For an axis: bit7 is dir, bits 6:0 are magnitude.
- host_commit  in  1  asynchronous; a rising edge marks the shadow set as pending.
- host_clr  in  1  asynchronous; a rising edge clears the sticky status flags.
- busy_in  in  4  busy outputs of the axis generators.
- N_out  out  32  active setpoints; axis k uses bits [8k+7:8k].
- WR_out  out  4  load strobes to the axis generators.
- tick_out  out  1  one-cycle pulse at each period start (host interrupt).
- overrun  out  4  sticky flag per axis.
- underrun  out  1  sticky flag.
- seq_busy  out  1  high while the sequencer is in SETUP or STROBE.

## Operation
- host_wr, host_commit and host_clr each pass through a 3-flop chain. The event is ff2 & ~ff3.
- host_addr and host_data are quasi-static. They are sampled on the host_wr event edge and must be held for 4 clk cycles after host_wr rises.
- A write event updates shadow[addr] or en_mask. Writes are allowed in any state because the shadow set is copied in a single edge.
- A commit event sets pending.
- Period counter:
  - Counts 0 to TICK_CYCLES-1 and then wraps.
  - The tick edge is the clk edge where the count equals TICK_CYCLES-1.
  - tick_out is high during the first cycle after the wrap, when the count is 0.
- State machine, IDLE → SETUP → STROBE → IDLE:
  - At the tick edge with pending=1:
    - N_out ← shadow; pending ← 0; state ← SETUP.
    - overrun[k] is set if en_mask[k] & busy_in[k].
  - At the tick edge with pending=0: underrun is set, N_out is unchanged, no strobe is issued, and the state stays IDLE.
  - SETUP lasts SETUP_CYC cycles, then the state goes to STROBE.
  - In STROBE, WR_out = en_mask for STROBE_CYC cycles, then the state goes to IDLE.
  - WR_out is 0 in all other states.
- A disabled axis still receives its N_out update but gets no WR_out pulse and is not checked for overrun.
- The en_mask value sampled at the tick edge applies for the whole sequence. A later en_mask write takes effect at the next tick.
- Simultaneous events:
  - Commit event and tick edge in the same cycle: the tick sees the old pending, and pending=1 is applied afterwards for the next tick.
  - Write event and tick edge in the same cycle: N_out takes the old shadow value, and the write then lands in the shadow.
  - Clear event and a flag-set in the same cycle: set wins.
- Reset mid-sequence: WR_out drops immediately (asynchronous), and the next sequence occurs no earlier than a full period after reset release.

## Timing
- Reset values:
  - Outputs: N_out=0, WR_out=0, tick_out=0, overrun=0, underrun=0, seq_busy=0.
  - Internal: shadow=0, en_mask=4'hF, pending=0, counter=0, state IDLE, sync flops 0.
- Host to register latency: the shadow updates on the 3rd clk edge after host_wr rises, assuming setup is met.
- Sequence timing, with the tick edge at E:
  - N_out is valid from E+1.
  - seq_busy is high from E+1 through E+SETUP_CYC+STROBE_CYC.
  - WR_out is high from cycle E+SETUP_CYC+1 for STROBE_CYC cycles.
  - With the defaults: WR_out rises 3 cycles after E and falls 5 cycles after E.
- At most one load sequence per period. Subsequent commits before the next tick only re-set pending; the latest shadow content at the tick edge is what gets loaded.

## Test plan
- Reset and first load:
  - Stimulus: after rst, write axis0=0x85 and axis1=0x32, then commit.
  - Required: at the first tick, N_out[15:0]=0x3285; WR_out=4'hF rises 3 cycles after the tick and stays high 2 cycles; no flags set.
- Underrun:
  - Stimulus: no commit for one period.
  - Required: underrun=1 after the tick edge, WR_out stays 0, and N_out holds its previous value. A host_clr event clears underrun.
- Overrun and mask:
  - Stimulus: en_mask=4'b0101, busy_in=4'b0011 at the tick, commit pending.
  - Required: overrun=4'b0001, and WR_out=4'b0101 during STROBE.
- Commit on the tick edge:
  - Stimulus: time the commit event to land exactly on the tick edge.
  - Required: no load and underrun=1 for that tick; the load happens at the next tick.
- Write on the tick edge:
  - Stimulus: shadow axis2=0x10, then write 0x20 so its event lands on the tick edge.
  - Required: N_out[23:16]=0x10 for this period; with a commit, 0x20 is loaded at the next tick.
- Asynchronous reset during STROBE:
  - Stimulus: assert rst while WR_out is high.
  - Required: WR_out and N_out are 0 within the same cycle, and no strobe occurs until the first tick after release.
